i2c_slave_rx: RTL and testbench
===============================

Name: i2c_slave_rx

Overview:
- Write-only I2C target that receives bytes from the team's `master` block over the shared open-drain SDA/SCL pair.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs matching write transfers, and presents each received data byte with a one-cycle valid strobe.
- Serves as the loopback partner for the `master` bench and as the receive end in the synth flow.

Parameters:
MESSAGE_LENGTH, 8, data byte width; SCL clock pulses per byte before ACK.
ADDR_WIDTH, 7, target address width; address phase is ADDR_WIDTH+1 bits including R/W.
ADDRESS, 7'h2A, own target address.

Ports:
clk  input  1  system clock; SCL is at least 8x slower.
reset  input  1  synchronous, active-high reset.
scl  input  1  I2C clock line, resolved bus level.
sda_in  input  1  I2C data line, resolved bus level.
sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
data  output  MESSAGE_LENGTH  last received byte, MSB first on the wire.
data_valid  output  1  one-clk pulse when `data` updates.
addr_match  output  1  high from the address-ACK until STOP or START.
busy  output  1  high between START and STOP.

Behaviour:
- Reset values:
  - sda_oe=0, data=0, data_valid=0, addr_match=0, busy=0.
  - State IDLE, bit counter 0.
  - Synchronizer flops load 1, so the idle bus reads high.
- Input conditioning:
  - Two-flop synchronizer per line, then previous-sample register for edge detection.
  - Condition latency: 3 clk from pin change to detected event.
- Bus events, evaluated each clk on synchronized values:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Bit sample: SCL rising edge.
  - Drive/release point: SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE:
  - START -> ADDR, counter=0, busy=1.
- ADDR:
  - Shift sda on each SCL rise.
  - After ADDR_WIDTH+1 bits, at the next SCL fall, check the address and R/W bit.
  - Address equal and R/W=0 -> ADDR_ACK, sda_oe=1, addr_match=1.
  - Otherwise -> IGNORE; sda_oe stays 0 (NACK).
- ADDR_ACK:
  - Next SCL fall -> sda_oe=0, DATA, counter=0.
- DATA:
  - Shift on SCL rise.
  - At the SCL fall after the MESSAGE_LENGTH-th bit: data<=shift register, data_valid=1 for exactly that clk, sda_oe=1, -> DATA_ACK.
- DATA_ACK:
  - Next SCL fall -> sda_oe=0, DATA, counter=0.
  - Continuous bytes with no upper limit.
- IGNORE:
  - Wait for STOP or START; never drives SDA.
- Priority, highest first: reset, STOP, START, then bit/edge handling in the same clk.
- STOP in any state:
  - -> IDLE; sda_oe=0, addr_match=0, busy=0.
  - A partial byte is discarded, with no data_valid.
- Repeated START in any non-IDLE state:
  - -> ADDR, counter=0, sda_oe=0, addr_match=0; busy stays 1.
- START/STOP while SCL low: not an event.
- SDA change while SCL high in the middle of a bit: treated as START/STOP per the rules above.
- Reset mid-transfer:
  - All outputs return to reset values on the next clk edge.
  - The block releases SDA immediately and re-arms on the next START.
- Bit counter is $clog2(MESSAGE_LENGTH+1) wide.
- Counter saturates; it never wraps inside a byte.

Optional Feature:
- Macro: I2C_SLAVE_GLITCH_FILTER_EN.
- Defined:
  - Each synchronized line passes a 3-sample majority filter.
  - Single-clk glitches on SCL/SDA are suppressed.
  - Condition latency becomes 5 clk.
- Undefined:
  - No filter; 3-clk latency.
  - A 1-clk SDA glitch while SCL is high is a valid START/STOP.

Decomposition:
- Package i2c_pkg:
  - State enumeration for the six states.
  - Default MESSAGE_LENGTH, ADDR_WIDTH, ADDRESS localparams.
  - RW_WRITE=0 constant.
- Sub-module i2c_line_sync:
  - Synchronizer, optional majority filter, rise/fall pulse outputs.
  - Instantiated once for SCL and once for SDA.

Test Plan:
- Address match. Bench: 40 ns clk period, SCL period 800 ns, bus = sda_in AND NOT sda_oe.
  - Stimulus: START, 0x54 (0x2A, W), byte 0x5F, STOP.
  - Required: address ACK low for exactly the 9th SCL pulse; data=0x5F; one data_valid pulse; second ACK; busy falls 3 clk after STOP.
- Address mismatch.
  - Stimulus: START, 0x56 (0x2B, W), byte 0x95.
  - Required: sda_oe never 1; no data_valid; state IGNORE until STOP.
- Read request.
  - Stimulus: START, 0x55 (0x2A, R).
  - Required: NACK (sda_oe=0 on 9th pulse), addr_match=0.
- Multi-byte and repeated START.
  - Stimulus: START, 0x54, bytes 0x95, 0xF0, repeated START, 0x54, byte 0x0F, STOP.
  - Required: three data_valid pulses with data 0x95, 0xF0, 0x0F in order.
  - Required: addr_match drops for one address phase, then reasserts.
- Mid-transfer aborts.
  - Stimulus: STOP after 4 data bits.
  - Required: no data_valid; data keeps its previous value.
  - Stimulus: reset pulse during ADDR_ACK.
  - Required: sda_oe=0 on the next clk; the next full transfer of 0xAA is received correctly.
- Glitch filter.
  - With I2C_SLAVE_GLITCH_FILTER_EN: a 1-clk SDA low pulse while SCL is high is ignored (busy stays 0).
  - Without the macro: the same pulse sets busy=1.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C write-only target: FSM state codes, default
// geometry and small helper functions.
package i2c_pkg;

  localparam int            DEF_MESSAGE_LENGTH = 8;
  localparam int            DEF_ADDR_WIDTH     = 7;
  localparam logic [6:0]    DEF_ADDRESS        = 7'h2A;
  localparam logic          RW_WRITE           = 1'b0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ADDR     = 3'd1;
  localparam state_t ST_ADDR_ACK = 3'd2;
  localparam state_t ST_DATA     = 3'd3;
  localparam state_t ST_DATA_ACK = 3'd4;
  localparam state_t ST_IGNORE   = 3'd5;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one I2C line with edge pulses. Define
// I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter (+2 clk latency).
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;
  logic filt;

  // Flops load 1 so an idle bus never produces a spurious edge out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] hist_reg;
  logic       level_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_reg  <= 2'b11;
      level_reg <= 1'b1;
    end else begin
      hist_reg  <= {hist_reg[0], sync2_reg};
      level_reg <= maj3(sync2_reg, hist_reg[0], hist_reg[1]);
    end
  end

  assign filt = level_reg;
`else
  assign filt = sync2_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg <= 1'b1;
    end else begin
      prev_reg <= filt;
    end
  end

  assign level = filt;
  assign rise  = filt & ~prev_reg;
  assign fall  = ~filt & prev_reg;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: detects START/STOP, matches its address, ACKs write
// transfers and strobes each received byte. Optional I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter int                    MESSAGE_LENGTH = DEF_MESSAGE_LENGTH,
  parameter int                    ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] ADDRESS        = DEF_ADDRESS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      scl,
  input  logic                      sda_in,
  output logic                      sda_oe,
  output logic [MESSAGE_LENGTH-1:0] data,
  output logic                      data_valid,
  output logic                      addr_match,
  output logic                      busy
);

  localparam int SHIFT_W = max2(MESSAGE_LENGTH, ADDR_WIDTH + 1);
  localparam int CNT_W   = $clog2(max2(MESSAGE_LENGTH, ADDR_WIDTH + 1) + 1);
  localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(ADDR_WIDTH + 1);
  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(MESSAGE_LENGTH);

  // Line index 0 is SCL, 1 is SDA.
  logic [1:0] line_pin;
  logic [1:0] line_level;
  logic [1:0] line_rise;
  logic [1:0] line_fall;

  assign line_pin = {sda_in, scl};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      i2c_line_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (line_pin[gi]),
        .level (line_level[gi]),
        .rise  (line_rise[gi]),
        .fall  (line_fall[gi])
      );
    end
  endgenerate

  logic scl_level;
  logic scl_rise;
  logic scl_fall;
  logic sda_level;
  logic start_evt;
  logic stop_evt;

  assign scl_level = line_level[0];
  assign scl_rise  = line_rise[0];
  assign scl_fall  = line_fall[0];
  assign sda_level = line_level[1];
  assign start_evt = line_fall[1] & scl_level;
  assign stop_evt  = line_rise[1] & scl_level;

  state_t                    state_reg,      state_next;
  logic [CNT_W-1:0]          cnt_reg,        cnt_next;
  logic [SHIFT_W-1:0]        shift_reg,      shift_next;
  logic                      sda_oe_reg,     sda_oe_next;
  logic [MESSAGE_LENGTH-1:0] data_reg,       data_next;
  logic                      data_valid_reg, data_valid_next;
  logic                      addr_match_reg, addr_match_next;
  logic                      busy_reg,       busy_next;

  logic addr_ok;
  assign addr_ok = (shift_reg[ADDR_WIDTH:1] == ADDRESS) && (shift_reg[0] == RW_WRITE);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shift_next      = shift_reg;
    sda_oe_next     = sda_oe_reg;
    data_next       = data_reg;
    data_valid_next = 1'b0;
    addr_match_next = addr_match_reg;
    busy_next       = busy_reg;

    if (stop_evt) begin
      state_next      = ST_IDLE;
      cnt_next        = '0;
      sda_oe_next     = 1'b0;
      addr_match_next = 1'b0;
      busy_next       = 1'b0;
    end else if (start_evt) begin
      // Covers both the first START and a repeated START.
      state_next      = ST_ADDR;
      cnt_next        = '0;
      sda_oe_next     = 1'b0;
      addr_match_next = 1'b0;
      busy_next       = 1'b1;
    end else begin
      case (state_reg)
        ST_ADDR: begin
          if (scl_rise && cnt_reg != ADDR_BITS) begin
            shift_next = {shift_reg[SHIFT_W-2:0], sda_level};
            cnt_next   = cnt_reg + 1'b1;
          end else if (scl_fall && cnt_reg == ADDR_BITS) begin
            if (addr_ok) begin
              state_next      = ST_ADDR_ACK;
              sda_oe_next     = 1'b1;
              addr_match_next = 1'b1;
            end else begin
              state_next = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            state_next  = ST_DATA;
            sda_oe_next = 1'b0;
            cnt_next    = '0;
          end
        end
        ST_DATA: begin
          if (scl_rise && cnt_reg != DATA_BITS) begin
            shift_next = {shift_reg[SHIFT_W-2:0], sda_level};
            cnt_next   = cnt_reg + 1'b1;
          end else if (scl_fall && cnt_reg == DATA_BITS) begin
            state_next      = ST_DATA_ACK;
            data_next       = shift_reg[MESSAGE_LENGTH-1:0];
            data_valid_next = 1'b1;
            sda_oe_next     = 1'b1;
          end
        end
        default: begin
          // IDLE and IGNORE only react to START/STOP.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      sda_oe_reg     <= 1'b0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      addr_match_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shift_reg      <= shift_next;
      sda_oe_reg     <= sda_oe_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      addr_match_reg <= addr_match_next;
      busy_reg       <= busy_next;
    end
  end

  assign sda_oe     = sda_oe_reg;
  assign data       = data_reg;
  assign data_valid = data_valid_reg;
  assign addr_match = addr_match_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: drives an open-drain bus model
// (bus = master SDA AND NOT sda_oe) with 40 ns clk and 800 ns SCL.
module tb_i2c_slave_rx;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_sda;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] data;
  logic       data_valid;
  logic       addr_match;
  logic       busy;

  assign sda_bus = m_sda & ~sda_oe;

  always #20 clk = ~clk;

  i2c_slave_rx dut (
    .clk        (clk),
    .reset      (reset),
    .scl        (scl),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .data       (data),
    .data_valid (data_valid),
    .addr_match (addr_match),
    .busy       (busy)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         dv_count = 0;
  int         oe_cycles = 0;
  logic [7:0] dv_log [0:15];

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (dv_count < 16) dv_log[dv_count] = data;
      dv_count++;
    end
    if (sda_oe === 1'b1) oe_cycles++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic s);
    tick(5);
    m_sda = b;
    tick(5);
    scl = 1'b1;
    tick(5);
    s = sda_bus;
    tick(5);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic bus_start();
    if (scl === 1'b0) begin
      tick(5);
      m_sda = 1'b1;
      tick(5);
      scl = 1'b1;
      tick(5);
    end
    m_sda = 1'b0;
    tick(10);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(5);
    m_sda = 1'b0;
    tick(5);
    scl = 1'b1;
    tick(5);
    m_sda = 1'b1;
    tick(LAT + 5);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    scl   = 1'b1;
    m_sda = 1'b1;
    tick(3);
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL reset_addr_match: got %b expected 0", addr_match); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    tick(5);
    $display("test_reset done");
  endtask

  task automatic test_addr_match();
    int   dv0, oe0;
    logic ack;
    dv0 = dv_count;
    oe0 = oe_cycles;
    bus_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL am_busy_start: got %b expected 1", busy); end
    send_byte(8'h54, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL am_addr_ack: got %b expected 0", ack); end
    n_checks++; if (addr_match !== 1'b1) begin n_fail++; $display("FAIL am_addr_match: got %b expected 1", addr_match); end
    send_byte(8'h5F, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL am_data_ack: got %b expected 0", ack); end
    n_checks++; if (dv_count - dv0 !== 1) begin n_fail++; $display("FAIL am_dv_count: got %0d expected 1", dv_count - dv0); end
    n_checks++; if (data !== 8'h5F) begin n_fail++; $display("FAIL am_data: got %h expected 5f", data); end
    tick(5);
    m_sda = 1'b0;
    tick(5);
    scl = 1'b1;
    tick(5);
    m_sda = 1'b1;
    tick(LAT - 1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL am_busy_before_stop: got %b expected 1", busy); end
    tick(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL am_busy_after_stop: got %b expected 0", busy); end
    n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL am_match_after_stop: got %b expected 0", addr_match); end
    tick(10);
    // Two ACK windows, each exactly one SCL period long.
    n_checks++; if (oe_cycles - oe0 !== 40) begin n_fail++; $display("FAIL am_oe_cycles: got %0d expected 40", oe_cycles - oe0); end
    $display("test_addr_match: addr 54 byte 5f data=%h", data);
  endtask

  task automatic test_addr_mismatch();
    int   dv0, oe0;
    logic ack;
    dv0 = dv_count;
    oe0 = oe_cycles;
    bus_start();
    send_byte(8'h56, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mm_addr_nack: got %b expected 1", ack); end
    send_byte(8'h95, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mm_data_nack: got %b expected 1", ack); end
    n_checks++; if (busy !== 1'b1 || addr_match !== 1'b0) begin n_fail++; $display("FAIL mm_ignore: got busy=%b match=%b expected busy=1 match=0", busy, addr_match); end
    bus_stop();
    n_checks++; if (oe_cycles - oe0 !== 0) begin n_fail++; $display("FAIL mm_oe_cycles: got %0d expected 0", oe_cycles - oe0); end
    n_checks++; if (dv_count - dv0 !== 0) begin n_fail++; $display("FAIL mm_dv_count: got %0d expected 0", dv_count - dv0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mm_busy_after_stop: got %b expected 0", busy); end
    $display("test_addr_mismatch: addr 56 byte 95 ignored");
  endtask

  task automatic test_read_request();
    int   oe0;
    logic ack;
    oe0 = oe_cycles;
    bus_start();
    send_byte(8'h55, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_nack: got %b expected 1", ack); end
    n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL rd_addr_match: got %b expected 0", addr_match); end
    bus_stop();
    n_checks++; if (oe_cycles - oe0 !== 0) begin n_fail++; $display("FAIL rd_oe_cycles: got %0d expected 0", oe_cycles - oe0); end
    $display("test_read_request: addr 55 nacked");
  endtask

  task automatic test_repeated_start();
    int   dv0;
    logic ack;
    dv0 = dv_count;
    bus_start();
    send_byte(8'h54, ack);
    send_byte(8'h95, ack);
    send_byte(8'hF0, ack);
    n_checks++; if (addr_match !== 1'b1) begin n_fail++; $display("FAIL rs_match_before: got %b expected 1", addr_match); end
    bus_start();
    n_checks++; if (addr_match !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rs_after_rstart: got match=%b busy=%b expected match=0 busy=1", addr_match, busy); end
    send_byte(8'h54, ack);
    n_checks++; if (addr_match !== 1'b1) begin n_fail++; $display("FAIL rs_match_again: got %b expected 1", addr_match); end
    send_byte(8'h0F, ack);
    bus_stop();
    n_checks++; if (dv_count - dv0 !== 3) begin n_fail++; $display("FAIL rs_dv_count: got %0d expected 3", dv_count - dv0); end
    n_checks++; if (dv_log[dv0] !== 8'h95) begin n_fail++; $display("FAIL rs_byte0: got %h expected 95", dv_log[dv0]); end
    n_checks++; if (dv_log[dv0+1] !== 8'hF0) begin n_fail++; $display("FAIL rs_byte1: got %h expected f0", dv_log[dv0+1]); end
    n_checks++; if (dv_log[dv0+2] !== 8'h0F) begin n_fail++; $display("FAIL rs_byte2: got %h expected 0f", dv_log[dv0+2]); end
    $display("test_repeated_start: bytes 95 f0 | rstart | 0f");
  endtask

  task automatic test_stop_abort();
    int   dv0;
    logic ack, s;
    dv0 = dv_count;
    bus_start();
    send_byte(8'h54, ack);
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    bus_stop();
    n_checks++; if (dv_count - dv0 !== 0) begin n_fail++; $display("FAIL ab_dv_count: got %0d expected 0", dv_count - dv0); end
    n_checks++; if (data !== 8'h0F) begin n_fail++; $display("FAIL ab_data_kept: got %h expected 0f", data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_busy: got %b expected 0", busy); end
    $display("test_stop_abort: stop after 4 data bits");
  endtask

  task automatic test_reset_in_ack();
    int         dv0;
    logic       ack, s;
    logic [7:0] addr_byte;
    addr_byte = 8'h54;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(addr_byte[i], s);
    tick(5);
    n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_ack_driven: got %b expected 1", sda_oe); end
    reset = 1'b1;
    tick(1);
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_release: got %b expected 0", sda_oe); end
    n_checks++; if (busy !== 1'b0 || addr_match !== 1'b0) begin n_fail++; $display("FAIL rst_outputs: got busy=%b match=%b expected 0 0", busy, addr_match); end
    reset = 1'b0;
    m_sda = 1'b1;
    tick(4);
    scl = 1'b1;
    tick(10);
    scl = 1'b0;
    bus_stop();
    dv0 = dv_count;
    bus_start();
    send_byte(8'h54, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_rearm_ack: got %b expected 0", ack); end
    send_byte(8'hAA, ack);
    bus_stop();
    n_checks++; if (dv_count - dv0 !== 1) begin n_fail++; $display("FAIL rst_dv_count: got %0d expected 1", dv_count - dv0); end
    n_checks++; if (data !== 8'hAA) begin n_fail++; $display("FAIL rst_data: got %h expected aa", data); end
    $display("test_reset_in_ack: reset in ADDR_ACK, then byte aa");
  endtask

  task automatic test_glitch();
    logic seen;
    logic expect_seen;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    expect_seen = 1'b0;
`else
    expect_seen = 1'b1;
`endif
    seen  = 1'b0;
    m_sda = 1'b0;
    tick(1);
    m_sda = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (busy === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== expect_seen) begin n_fail++; $display("FAIL glitch_busy: got %b expected %b", seen, expect_seen); end
    tick(10);
    $display("test_glitch: 1-clk SDA low pulse, busy seen=%b", seen);
  endtask

  initial begin
    test_reset();
    test_addr_match();
    test_addr_mismatch();
    test_read_request();
    test_repeated_start();
    test_stop_abort();
    test_reset_in_ack();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
